// File: rtl/tinker_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tinker_mem_arbiter
//
// Purpose:
//   Shares the single-ported tinker memory between instruction fetch (F) and
//   data load/store (D). One access is in flight at a time. A request is
//   accepted over a valid/ready handshake in IDLE. The access is issued for one
//   cycle, the arbiter waits MEM_LAT cycles for read data, and then it returns a
//   one-cycle response pulse to the requester that won.
//
//   Default policy: data first. If fetch loses STARVE_MAX consecutive
//   arbitrations while it is requesting, fetch is forced to win.
//
//   Optional build macro ARB_RR_EN: when it is defined, a tie goes to the side
//   opposite the last grant (round robin), and no starvation counter exists.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   f_req_valid/ready   fetch request handshake, f_addr = byte address
//   f_resp_valid/data   fetch response pulse, low 32 bits of the memory word
//   d_req_valid/ready   data request handshake; d_we, d_addr, d_wdata
//   d_resp_valid/data   load data or store acknowledge (data 0 for a store)
//   mem_en/we/addr/wdata registered memory strobe, active only in ISSUE
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module tinker_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_resp_valid,
    output logic [31:0]       f_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Latched request attributes still needed after ISSUE
    logic                r_id_f;       // 1 = fetch owns the access
    logic                r_we;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [DATA_W-1:0]   r_rdata;

    // Registered memory strobe and payload
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    // Arbitration
    logic                w_prio_f;     // fetch wins a tie
    logic                w_f_wins;
    logic                w_d_wins;
    logic                w_hs_f;
    logic                w_hs_d;
    logic                w_hs;
    logic                w_last_wait;

    // Mux of the winning request
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic                w_req_we;

    // -------------------------------------------------------------------------
    // Tie-break priority
    // -------------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic                r_last_f;     // 1 = last grant went to fetch

    assign w_prio_f = !r_last_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_f <= 1'b0;
        end else if (w_hs) begin
            r_last_f <= w_hs_f;
        end
    end
`else
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_prio_f = (r_starve_cnt == STARVE_W'(STARVE_MAX));

    // Counts grants to D that fetch lost while requesting. It saturates, so
    // fetch keeps priority until it is actually granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_hs_f) begin
            r_starve_cnt <= '0;
        end else if (w_hs_d && f_req_valid && !w_prio_f) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end
`endif

    assign w_f_wins = f_req_valid && (!d_req_valid || w_prio_f);
    assign w_d_wins = d_req_valid && !w_f_wins;

    assign w_hs_f = f_req_ready && f_req_valid;
    assign w_hs_d = d_req_ready && d_req_valid;
    assign w_hs   = w_hs_f || w_hs_d;

    assign w_req_addr  = w_hs_f ? f_addr : d_addr;
    assign w_req_we    = w_hs_d && d_we;
    assign w_req_wdata = w_hs_d ? d_wdata : '0;

    assign w_last_wait = (r_wait_cnt == CNT_W'(1));

    // -------------------------------------------------------------------------
    // Next state and ready. Ready is also gated by reset, so no handshake can
    // be reported in a cycle that the reset is about to discard.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        f_req_ready = 1'b0;
        d_req_ready = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    f_req_ready = w_f_wins;
                    d_req_ready = w_d_wins;
                end
                if (w_f_wins || w_d_wins) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_last_wait) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_id_f     <= 1'b0;
            r_we       <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_id_f <= w_hs_f;
                r_we   <= w_req_we;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= CNT_W'(MEM_LAT);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory strobe. It is loaded on the handshake edge, so it is high exactly
    // during ISSUE, and it is zero in every other cycle. Because ISSUE lasts
    // one cycle, a store writes exactly once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_hs) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_req_we;
            r_mem_addr  <= w_req_addr;
            r_mem_wdata <= w_req_wdata;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Read data capture in the last WAIT cycle. The captured value is only
    // visible through the gated response outputs, so it needs no reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && w_last_wait) begin
            r_rdata <= mem_rdata;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign f_resp_valid = (r_state == S_RESP) && r_id_f;
    assign d_resp_valid = (r_state == S_RESP) && !r_id_f;

    // A store still captures the memory bus, but it reports zero data.
    assign f_resp_data = f_resp_valid ? r_rdata[31:0] : 32'h0;
    assign d_resp_data = (d_resp_valid && !r_we) ? r_rdata : '0;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
module tb_tinker_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int NGRANT     = 10;
`ifdef ARB_RR_EN
    localparam logic [0:NGRANT-1] ORDER = 10'b1010101010;
`else
    localparam logic [0:NGRANT-1] ORDER = 10'b0000100001;
`endif
    localparam logic [63:0] F0_WORD = 64'hAAAA5555_12345678;
    localparam logic [63:0] F1_WORD = 64'h0F0F0F0F_9ABCDEF0;
    localparam logic [63:0] ST_DATA = 64'hDEADBEEF_CAFEF00D;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req_valid, f_req_ready, f_resp_valid;
    logic [31:0] f_addr, f_resp_data;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_resp_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    tinker_mem_arbiter #(
        .ADDR_W(32), .DATA_W(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: unwritten words return a preload or an address pattern.
    logic [63:0] mem_arr [0:65535];
    logic        mem_ok  [0:65535];
    logic [63:0] rd_pipe [0:MEM_LAT-1];

    function automatic logic [63:0] rd_word(input logic [31:0] a);
        if (mem_ok[a[17:2]] === 1'b1) return mem_arr[a[17:2]];
        if (a == 32'h2000) return F0_WORD;
        if (a == 32'h2004) return F1_WORD;
        return {a, ~a};
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[17:2]] <= mem_wdata;
            mem_ok[mem_addr[17:2]]  <= 1'b1;
        end
        rd_pipe[0] <= mem_en ? rd_word(mem_addr) : 64'h5A5A_5A5A_5A5A_5A5A;
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Event logs written by the monitor only.
    typedef struct { int cyc; logic side; } hs_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [63:0] wdata; } en_t;
    typedef struct { int cyc; logic side; logic [63:0] data; } rs_t;
    typedef struct { logic side; logic [63:0] data; } ex_t;

    hs_t hs_log[$];
    en_t en_log[$];
    rs_t rs_log[$];
    int  we_cnt = 0;

    always @(negedge clk) begin
        if (f_req_valid && f_req_ready) hs_log.push_back('{cyc, 1'b1});
        if (d_req_valid && d_req_ready) hs_log.push_back('{cyc, 1'b0});
        if (mem_en) en_log.push_back('{cyc, mem_we, mem_addr, mem_wdata});
        if (mem_we) we_cnt <= we_cnt + 1;
        if (f_resp_valid) rs_log.push_back('{cyc, 1'b1, {32'h0, f_resp_data}});
        if (d_resp_valid) rs_log.push_back('{cyc, 1'b0, d_resp_data});
    end

    ex_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  hp = 0, ep = 0, rp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next logged handshake, then returns 1 time unit after the
    // handshake edge.
    task automatic wait_hs(input string tag, input logic side, output int hcyc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (hs_log.size() > hp) break;
        end
        check({tag, "_hs_seen"}, 64'(hs_log.size() > hp), 64'd1);
        if (hs_log.size() > hp) begin
            hcyc = hs_log[hp].cyc;
            check({tag, "_hs_side"}, 64'(hs_log[hp].side), 64'(side));
            hp++;
        end else begin
            hcyc = -1000;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_req(input string tag, input logic side, input logic we,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          output int hcyc);
        if (side) begin
            f_req_valid = 1'b1; f_addr = addr;
        end else begin
            d_req_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        wait_hs(tag, side, hcyc);
        f_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int rcyc);
        ex_t e;
        rs_t r;
        for (int i = 0; i < 40 && rs_log.size() <= rp; i++) begin
            @(negedge clk); #1;
        end
        check({tag, "_resp_seen"}, 64'(rs_log.size() > rp), 64'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (rs_log.size() > rp) begin
            r = rs_log[rp];
            rp++;
            check({tag, "_resp_side"}, 64'(r.side), 64'(e.side));
            check({tag, "_resp_data"}, r.data, e.data);
            rcyc = r.cyc;
        end else begin
            rcyc = -1000;
        end
    endtask

    task automatic chk_en(input string tag, input int hcyc, input logic we,
                          input logic [31:0] addr, input logic [63:0] wdata);
        check({tag, "_en_seen"}, 64'(en_log.size() > ep), 64'd1);
        if (en_log.size() > ep) begin
            check({tag, "_en_cyc"}, 64'(en_log[ep].cyc - hcyc), 64'd1);
            check({tag, "_en_we"}, 64'(en_log[ep].we), 64'(we));
            check({tag, "_en_addr"}, 64'(en_log[ep].addr), 64'(addr));
            check({tag, "_en_wdata"}, en_log[ep].wdata, wdata);
            ep++;
        end
    endtask

    initial begin
        int h, h2, rc, we0, n;
        reset = 1'b1;
        f_req_valid = 1'b0; f_addr = '0;
        d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({f_req_ready, d_req_ready, f_resp_valid, d_resp_valid, mem_en, mem_we}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", 64'({f_req_ready, d_req_ready, f_resp_valid, d_resp_valid, mem_en, mem_we}), 64'd0);
        check("idle_rdata", {f_resp_data, d_resp_data[31:0]}, 64'd0);
        check("idle_drdata_hi", 64'(d_resp_data[63:32]), 64'd0);
        @(posedge clk); #1;

        // Single fetch
        do_req("t1", 1'b1, 1'b0, 32'h2000, 64'h0, h);
        exp_q.push_back('{1'b1, 64'h12345678});
        wait_resp("t1", rc);
        chk_en("t1", h, 1'b0, 32'h2000, 64'h0);
        check("t1_resp_lat", 64'(rc - h), 64'(2 + MEM_LAT));

        // Store then load
        we0 = we_cnt;
        do_req("t2s", 1'b0, 1'b1, 32'h10000, ST_DATA, h);
        exp_q.push_back('{1'b0, 64'h0});
        wait_resp("t2s", rc);
        chk_en("t2s", h, 1'b1, 32'h10000, ST_DATA);
        check("t2s_we_pulses", 64'(we_cnt - we0), 64'd1);
        check("t2s_resp_lat", 64'(rc - h), 64'(2 + MEM_LAT));
        do_req("t2l", 1'b0, 1'b0, 32'h10000, 64'h0, h);
        exp_q.push_back('{1'b0, ST_DATA});
        wait_resp("t2l", rc);
        chk_en("t2l", h, 1'b0, 32'h10000, 64'h0);

        // Reset during WAIT of a load
        do_req("t4a", 1'b0, 1'b0, 32'h10000, 64'h0, h);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t4_wait_en", 64'(mem_en), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_rst_ctrl", 64'({f_req_ready, d_req_ready, f_resp_valid, d_resp_valid, mem_en, mem_we}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10000; d_wdata = 64'h0;
        @(negedge clk);
        check("t4_ready_after_rst", 64'(d_req_ready), 64'd1);
        check("t4_no_resp", 64'(d_resp_valid), 64'd0);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        check("t4_hs_seen", 64'(hs_log.size() > hp), 64'd1);
        h2 = (hs_log.size() > hp) ? hs_log[hp].cyc : -1000;
        hp = hs_log.size();
        exp_q.push_back('{1'b0, ST_DATA});
        wait_resp("t4b", rc);
        check("t4_resp_count", 64'(rs_log.size()), 64'(rp));
        chk_en("t4a", h, 1'b0, 32'h10000, 64'h0);
        chk_en("t4b", h2, 1'b0, 32'h10000, 64'h0);

        // Back-to-back fetches
        f_req_valid = 1'b1; f_addr = 32'h2000;
        wait_hs("t5a", 1'b1, h);
        exp_q.push_back('{1'b1, F0_WORD & 64'hFFFF_FFFF});
        f_addr = 32'h2004;
        wait_hs("t5b", 1'b1, h2);
        exp_q.push_back('{1'b1, F1_WORD & 64'hFFFF_FFFF});
        f_req_valid = 1'b0;
        check("t5_hs_gap", 64'(h2 - h), 64'(MEM_LAT + 3));
        wait_resp("t5a", rc);
        wait_resp("t5b", rc);
        chk_en("t5a", h, 1'b0, 32'h2000, 64'h0);
        chk_en("t5b", h2, 1'b0, 32'h2004, 64'h0);

        // Both requesters held valid from reset
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        f_req_valid = 1'b1; f_addr = 32'h2000;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10000; d_wdata = 64'h0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk); #1;
            if (hs_log.size() >= hp + NGRANT) break;
        end
        @(posedge clk); #1;
        f_req_valid = 1'b0;
        d_req_valid = 1'b0;
        check("t3_grants_seen", 64'(hs_log.size() >= hp + NGRANT), 64'd1);
        n = (hs_log.size() >= hp + NGRANT) ? NGRANT : hs_log.size() - hp;
        for (int i = 0; i < n; i++) begin
            check($sformatf("t3_grant%0d", i), 64'(hs_log[hp + i].side), 64'(ORDER[i]));
            exp_q.push_back('{ORDER[i], ORDER[i] ? 64'h12345678 : ST_DATA});
        end
        hp += n;
        for (int i = 0; i < n; i++) wait_resp($sformatf("t3_resp%0d", i), rc);

        // Nothing left over
        repeat (10) @(posedge clk);
        #1;
        check("end_exp_empty", 64'(exp_q.size()), 64'd0);
        check("end_no_stray_resp", 64'(rs_log.size()), 64'(rp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
